// File: rtl/membus_arbiter_pkg.sv
// Shared types for the fetch/data memory bus arbiter.
// Round-robin arbitration is enabled by defining MEMBUS_ARB_RR_EN.
package membus_arbiter_pkg;

    localparam int XLEN              = 64;
    localparam int MEMBUS_DATA_WIDTH = 64;

    typedef logic [XLEN-1:0] Addr;
    typedef logic [4:0]      AMOOp;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT
    } ArbState;

    typedef enum logic {
        FETCH,
        DATA
    } ArbOwner;

    // Fetches are always full doubleword reads
    localparam logic [2:0] FUNCT3_D = 3'b011;

endpackage

// File: rtl/membus_arbiter_if.sv
// Bundle of fetch, data and memory-side handshakes around the arbiter.
// slave: arbiter view; master: requester/memory environment view.
interface membus_arbiter_if #(
    parameter int ADDR_W = membus_arbiter_pkg::XLEN,
    parameter int DATA_W = membus_arbiter_pkg::MEMBUS_DATA_WIDTH
);
    import membus_arbiter_pkg::*;

    logic              i_valid;
    logic              i_ready;
    logic [ADDR_W-1:0] i_addr;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic                d_valid;
    logic                d_ready;
    logic [ADDR_W-1:0]   d_addr;
    logic                d_wen;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_wmask;
    logic                d_is_amo;
    AMOOp                d_amoop;
    logic                d_aq;
    logic                d_rl;
    logic [2:0]          d_funct3;
    logic                d_rvalid;
    logic [DATA_W-1:0]   d_rdata;

    logic                m_valid;
    logic                m_ready;
    logic [ADDR_W-1:0]   m_addr;
    logic                m_wen;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wmask;
    logic                m_is_amo;
    AMOOp                m_amoop;
    logic                m_aq;
    logic                m_rl;
    logic [2:0]          m_funct3;
    logic                m_rvalid;
    logic [DATA_W-1:0]   m_rdata;

    modport slave (
        input  i_valid, i_addr,
        output i_ready, i_rvalid, i_rdata,
        input  d_valid, d_addr, d_wen, d_wdata, d_wmask,
        input  d_is_amo, d_amoop, d_aq, d_rl, d_funct3,
        output d_ready, d_rvalid, d_rdata,
        output m_valid, m_addr, m_wen, m_wdata, m_wmask,
        output m_is_amo, m_amoop, m_aq, m_rl, m_funct3,
        input  m_ready, m_rvalid, m_rdata
    );

    modport master (
        output i_valid, i_addr,
        input  i_ready, i_rvalid, i_rdata,
        output d_valid, d_addr, d_wen, d_wdata, d_wmask,
        output d_is_amo, d_amoop, d_aq, d_rl, d_funct3,
        input  d_ready, d_rvalid, d_rdata,
        input  m_valid, m_addr, m_wen, m_wdata, m_wmask,
        input  m_is_amo, m_amoop, m_aq, m_rl, m_funct3,
        output m_ready, m_rvalid, m_rdata
    );

endinterface

// File: rtl/membus_arb_sel.sv
// Combinational two-way requester selector: fixed DATA priority,
// or alternating on contention when MEMBUS_ARB_RR_EN is defined.
module membus_arb_sel
    import membus_arbiter_pkg::*;
(
    input  logic    i_valid,
    input  logic    d_valid,
`ifdef MEMBUS_ARB_RR_EN
    input  ArbOwner last,
`endif
    output logic    any,
    output ArbOwner pick
);

    always_comb begin
        any  = i_valid | d_valid;
        pick = FETCH;
        unique case (1'b1)
            (i_valid & d_valid): begin
`ifdef MEMBUS_ARB_RR_EN
                pick = (last == DATA) ? FETCH : DATA;
`else
                pick = DATA;
`endif
            end
            (d_valid & ~i_valid): pick = DATA;
            default:              pick = FETCH;
        endcase
    end

endmodule

// File: rtl/membus_arbiter.sv
// Fetch/data arbiter for the shared core memory bus, one outstanding txn.
// Optional round-robin on contention via MEMBUS_ARB_RR_EN.
module membus_arbiter
    import membus_arbiter_pkg::*;
#(
    parameter int ADDR_W = XLEN,
    parameter int DATA_W = MEMBUS_DATA_WIDTH
) (
    input logic              clk,
    input logic              rst,
    membus_arbiter_if.slave  bus
);

    ArbState state_q;
    ArbOwner owner_q;
    ArbOwner pick;
    ArbOwner gnt;
    logic    any;
    logic    req_v;

`ifdef MEMBUS_ARB_RR_EN
    ArbOwner last_q;
`endif

    membus_arb_sel u_sel (
        .i_valid (bus.i_valid),
        .d_valid (bus.d_valid),
`ifdef MEMBUS_ARB_RR_EN
        .last    (last_q),
`endif
        .any     (any),
        .pick    (pick)
    );

    // Once a request is presented, the grant is locked to its owner
    assign gnt = (state_q == IDLE) ? pick : owner_q;

    always_comb begin
        req_v = 1'b0;
        case (state_q)
            IDLE:    req_v = any;
            HOLD:    req_v = (owner_q == DATA) ? bus.d_valid
                                               : bus.i_valid;
            default: req_v = 1'b0;
        endcase
    end

    always_comb begin
        bus.m_valid  = req_v;
        bus.m_addr   = {ADDR_W{1'b0}};
        bus.m_wen    = 1'b0;
        bus.m_wdata  = {DATA_W{1'b0}};
        bus.m_wmask  = {(DATA_W/8){1'b0}};
        bus.m_is_amo = 1'b0;
        bus.m_amoop  = '0;
        bus.m_aq     = 1'b0;
        bus.m_rl     = 1'b0;
        bus.m_funct3 = 3'b000;
        if (req_v && gnt == DATA) begin
            bus.m_addr   = bus.d_addr;
            bus.m_wen    = bus.d_wen;
            bus.m_wdata  = bus.d_wdata;
            bus.m_wmask  = bus.d_wmask;
            bus.m_is_amo = bus.d_is_amo;
            bus.m_amoop  = bus.d_amoop;
            bus.m_aq     = bus.d_aq;
            bus.m_rl     = bus.d_rl;
            bus.m_funct3 = bus.d_funct3;
        end else if (req_v) begin
            bus.m_addr   = bus.i_addr;
            bus.m_funct3 = FUNCT3_D;
        end
    end

    assign bus.i_ready  = req_v & (gnt == FETCH) & bus.m_ready;
    assign bus.d_ready  = req_v & (gnt == DATA) & bus.m_ready;

    assign bus.i_rvalid = (state_q == WAIT) & (owner_q == FETCH)
                        & bus.m_rvalid;
    assign bus.d_rvalid = (state_q == WAIT) & (owner_q == DATA)
                        & bus.m_rvalid;
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= FETCH;
`ifdef MEMBUS_ARB_RR_EN
            last_q  <= FETCH;
`endif
        end else begin
`ifdef MEMBUS_ARB_RR_EN
            if (req_v && bus.m_ready) last_q <= gnt;
`endif
            case (state_q)
                IDLE: begin
                    if (any) begin
                        owner_q <= pick;
                        state_q <= bus.m_ready ? WAIT : HOLD;
                    end
                end
                HOLD: begin
                    if (!req_v)           state_q <= IDLE;
                    else if (bus.m_ready) state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.m_rvalid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// Randomized bench for membus_arbiter against a transaction-level model.
// Follows MEMBUS_ARB_RR_EN to pick the expected arbitration policy.
module tb_membus_arbiter;
    import membus_arbiter_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MQ = 1 + AW + 1 + DW + DW/8 + 1 + 5 + 1 + 1 + 3;
`ifdef MEMBUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    membus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    membus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: at most one transaction in flight; it is either still
    // being offered to memory or accepted and awaiting its response.
    bit has_txn   = 0;
    bit accepted  = 0;
    bit txn_data  = 0;
    bit last_data = 0;
    bit i_took    = 0;
    bit d_took    = 0;

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mdl_eval(output bit mv, output bit to_data);
        mv = 1'b0;
        to_data = 1'b0;
        if (!has_txn) begin
            if (bus.i_valid && bus.d_valid)
                to_data = RR ? !last_data : 1'b1;
            else
                to_data = bus.d_valid;
            mv = bus.i_valid || bus.d_valid;
        end else if (!accepted) begin
            to_data = txn_data;
            mv = txn_data ? bus.d_valid : bus.i_valid;
        end
    endtask

    task automatic do_checks();
        bit mv, td;
        logic [MQ-1:0] e_req, o_req;
        logic [3:0]    e_hs, o_hs;
        bit            resp;
        mdl_eval(mv, td);
        if (!mv)
            e_req = '0;
        else if (td)
            e_req = {1'b1, bus.d_addr, bus.d_wen, bus.d_wdata, bus.d_wmask,
                     bus.d_is_amo, bus.d_amoop, bus.d_aq, bus.d_rl,
                     bus.d_funct3};
        else
            e_req = {1'b1, bus.i_addr, 1'b0, {DW{1'b0}}, {(DW/8){1'b0}},
                     1'b0, 5'd0, 1'b0, 1'b0, 3'b011};
        o_req = {bus.m_valid, bus.m_addr, bus.m_wen, bus.m_wdata,
                 bus.m_wmask, bus.m_is_amo, bus.m_amoop, bus.m_aq,
                 bus.m_rl, bus.m_funct3};
        resp = has_txn && accepted && bus.m_rvalid;
        e_hs = {mv && !td && bus.m_ready, mv && td && bus.m_ready,
                resp && !txn_data, resp && txn_data};
        o_hs = {bus.i_ready, bus.d_ready, bus.i_rvalid, bus.d_rvalid};
        check("mreq", 256'(o_req), 256'(e_req));
        check("hs", 256'(o_hs), 256'(e_hs));
        check("i_rdata", 256'(bus.i_rdata), 256'(bus.m_rdata));
        check("d_rdata", 256'(bus.d_rdata), 256'(bus.m_rdata));
    endtask

    task automatic mdl_update();
        bit mv, td;
        mdl_eval(mv, td);
        i_took = mv && !td && bus.m_ready;
        d_took = mv && td && bus.m_ready;
        if (!has_txn) begin
            if (mv) begin
                has_txn  = 1'b1;
                txn_data = td;
                accepted = bus.m_ready;
                if (bus.m_ready) last_data = td;
            end
        end else if (!accepted) begin
            if (!mv) begin
                has_txn = 1'b0;
            end else if (bus.m_ready) begin
                accepted  = 1'b1;
                last_data = td;
            end
        end else if (bus.m_rvalid) begin
            has_txn = 1'b0;
        end
    endtask

    task automatic mdl_reset();
        has_txn   = 1'b0;
        accepted  = 1'b0;
        last_data = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        do_checks();
        @(posedge clk);
        mdl_update();
        #1;
    endtask

    task automatic new_i();
        bus.i_addr = {$urandom, $urandom};
    endtask

    task automatic new_d();
        logic [31:0] r;
        r = $urandom;
        bus.d_addr   = {$urandom, $urandom};
        bus.d_wdata  = {$urandom, $urandom};
        bus.d_wen    = r[0];
        bus.d_wmask  = r[8:1];
        bus.d_is_amo = r[9];
        bus.d_amoop  = r[14:10];
        bus.d_aq     = r[15];
        bus.d_rl     = r[16];
        bus.d_funct3 = r[19:17];
    endtask

    task automatic drive_rand();
        logic [31:0] r;
        r = $urandom;
        if (bus.i_valid && i_took) begin
            bus.i_valid = r[0];
            if (r[0]) new_i();
        end else if (!bus.i_valid) begin
            bus.i_valid = r[1];
            if (r[1]) new_i();
        end else if (r[7:2] == 6'd0) begin
            bus.i_valid = 1'b0;
        end
        if (bus.d_valid && d_took) begin
            bus.d_valid = r[8];
            if (r[8]) new_d();
        end else if (!bus.d_valid) begin
            bus.d_valid = r[9];
            if (r[9]) new_d();
        end else if (r[15:10] == 6'd0) begin
            bus.d_valid = 1'b0;
        end
        bus.m_ready  = r[16];
        bus.m_rvalid = (r[18:17] == 2'd0);
        bus.m_rdata  = {$urandom, $urandom};
    endtask

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_addr   = '0;
        bus.d_valid  = 1'b0;
        new_d();
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = 64'h0123_4567_89ab_cdef;

        #3;
        do_checks();
        @(posedge clk);
        #1 rst = 1'b1;

        for (int k = 0; k < 3000; k++) begin
            drive_rand();
            step();
        end

        bus.i_valid  = 1'b0;
        bus.d_valid  = 1'b0;
        bus.m_rvalid = 1'b1;
        step();
        bus.m_rvalid = 1'b0;
        step();

        // Fetch-only transaction with a 2-cycle response
        bus.i_valid = 1'b1;
        bus.i_addr  = 64'h1000;
        bus.m_ready = 1'b1;
        bus.m_rdata = 64'hDEAD_BEEF;
        step();
        bus.i_valid = 1'b0;
        bus.m_ready = 1'b0;
        step();
        bus.m_rvalid = 1'b1;
        step();
        bus.m_rvalid = 1'b0;
        step();

        // Async reset while waiting for a response
        bus.i_valid = 1'b1;
        bus.m_ready = 1'b1;
        step();
        bus.i_valid = 1'b0;
        bus.m_ready = 1'b0;
        step();
        #2;
        bus.m_rvalid = 1'b1;
        rst = 1'b0;
        #1;
        check("rst_mvalid", 256'(bus.m_valid), 256'(0));
        check("rst_rvalid", 256'({bus.i_rvalid, bus.d_rvalid}), 256'(0));
        mdl_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        bus.m_rvalid = 1'b0;
        step();

        // Back-to-back contention
        bus.m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.i_valid = 1'b1;
            bus.d_valid = 1'b1;
            new_i();
            new_d();
            step();
            bus.i_valid  = i_took ? 1'b0 : 1'b1;
            bus.d_valid  = d_took ? 1'b0 : 1'b1;
            bus.m_rvalid = 1'b1;
            step();
            bus.m_rvalid = 1'b0;
        end
        bus.i_valid = 1'b0;
        bus.d_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/membus_arbiter.md
# membus_arbiter

Two-requester arbiter that shares the single core memory bus between instruction fetch (read-only) and the data memory unit (loads, stores, AMOs). It sits between the core front-end/memory stage and the memory-side `core_data_if` slave. It forwards one request at a time, locks the grant until the downstream handshake completes, and routes the response back to the owner. It allows one outstanding transaction and adds no cycle of latency on the request or response path.

## Interface
Parameters:
- ADDR_W, XLEN (64), address width.
- DATA_W, MEMBUS_DATA_WIDTH (64), bus data width; mask width is DATA_W/8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-low.
- i_valid / i_ready  in / out  1  fetch request handshake.
- i_addr  in  ADDR_W  fetch address.
- i_rvalid  out  1  fetch response valid.
- i_rdata  out  DATA_W  fetch response data.
- d_valid / d_ready  in / out  1  data request handshake.
- d_addr, d_wen, d_wdata, d_wmask  in  ADDR_W / 1 / DATA_W / DATA_W/8  data request payload.
- d_is_amo, d_amoop, d_aq, d_rl, d_funct3  in  1 / 5 (AMOOp) / 1 / 1 / 3  AMO and size qualifiers.
- d_rvalid  out  1  data response valid.
- d_rdata  out  DATA_W  data response data.
- m_valid  out  1  downstream request.
- m_ready  in  1  downstream accept.
- m_addr, m_wen, m_wdata, m_wmask, m_is_amo, m_amoop, m_aq, m_rl, m_funct3  out  payload to memory.
- m_rvalid  in  1  downstream response valid.
- m_rdata  in  DATA_W  downstream response data.

## Operation
- States: IDLE, HOLD, WAIT. Owner register: FETCH or DATA.
- IDLE: select a requester.
  - Only one valid: select it.
  - Both valid: select DATA (fixed priority).
  - Drive m_valid=1 and the selected payload.
  - For fetch: m_wen=0, m_wmask=0, m_wdata=0, m_is_amo=0, m_amoop=0, m_aq=0, m_rl=0, m_funct3=3'b011.
  - Selected xx_ready = m_ready; the other ready = 0.
  - m_valid&m_ready: owner ← selected, state goes to WAIT.
  - m_valid&!m_ready: owner ← selected, state goes to HOLD.
- HOLD: payload comes from the owner only, regardless of the other requester. m_valid = owner valid. On accept, go to WAIT. If the owner drops valid (protocol violation), go to IDLE.
- WAIT: m_valid=0 and both ready=0.
  - m_rvalid is routed to the owner's rvalid, gated to the owner only.
  - On m_rvalid, go to IDLE. No new grant is given in the m_rvalid cycle.
- i_rdata and d_rdata both equal m_rdata at all times. Only the rvalid strobes qualify them.
- m_rvalid in IDLE or HOLD (stray response): ignored, neither rvalid asserts.
- Requesters must hold their payload stable from valid until ready. The arbiter does not register the payload; the outputs are combinational muxes.

## Timing
- Reset (rst low, async): state=IDLE, owner=FETCH, and last-grant=FETCH when configured.
- Every output resets to 0 except data buses that are mux pass-throughs: rdata follows m_rdata, and m_* payload is 0 while idle with no requester.
- Request path: the grant is combinational, with 0 added cycles. The earliest accept is the cycle the requester raises valid.
- Response path: combinational, 0 added cycles. A new grant is possible the cycle after m_rvalid at the earliest.
- Reset mid-transaction: the state is abandoned. A later m_rvalid arrives while in IDLE and is dropped.
- Simultaneous: a requester raising valid during WAIT waits, with ready=0, until IDLE.

## Configuration
- MEMBUS_ARB_RR_EN defined: round-robin. A last-grant register updates on each accept. When both requesters are valid in IDLE, the grant goes to the requester not granted last. Reset last-grant=FETCH, so DATA wins the first contention.
- Not defined: fixed DATA priority, and no last-grant register exists.

## Structure
- Shared package (eei/corectrl side):
  - ArbState enum {IDLE, HOLD, WAIT}.
  - ArbOwner enum {FETCH, DATA}.
  - Reuse of Addr, AMOOp, XLEN and MEMBUS_DATA_WIDTH.
- Sub-module: `membus_arb_sel`, the combinational two-way selector (fixed or RR) taking the valids and last-grant. It is instantiated once.
- Top module: holds the FSM, owner register, payload mux and response demux.

## Test plan
- Fetch only: i_valid=1, i_addr=0x1000, m_ready=1, response m_rvalid 2 cycles later with m_rdata=0xDEAD_BEEF -> m_addr=0x1000 and m_wen=0 in cycle 0, i_rvalid=1 in cycle 2, d_rvalid=0 throughout.
- Contention, fixed priority: i_valid=d_valid=1 in IDLE, d_addr=0x2008 store with wmask=0xF0 -> m_addr=0x2008, d_ready=1, i_ready=0. Fetch is granted the cycle after the data m_rvalid.
- HOLD lock: grant fetch with m_ready=0 for 3 cycles, raise d_valid in cycle 1 -> m_addr remains i_addr and d_ready=0 until fetch is accepted.
- Stray response: m_rvalid=1 in IDLE -> i_rvalid=d_rvalid=0 and the state stays IDLE.
- Async reset in WAIT: assert rst low mid-cycle -> i_rvalid=d_rvalid=0 and m_valid=0 immediately. A subsequent m_rvalid is ignored.
- With MEMBUS_ARB_RR_EN: 4 back-to-back contended requests -> grant order DATA, FETCH, DATA, FETCH.
